// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end that time-shares one 32-bit adder for add/subtract.
// Results come back registered and tagged with the owning requester id.

module add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  always_comb begin
    {cout_o, sum_o} = 33'(a_i) + 33'(b_i) + 33'(cin_i);
  end
endmodule

module addsub_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r0_op,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        r1_op,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_id,
  output logic [31:0] o_sum,
  output logic        o_cout,
  output logic        o_zero,
  output logic        busy
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            op_q, op_d, id_q, id_d, last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            o_valid_q, o_valid_d, o_id_q, o_id_d;
  logic [DW-1:0]   o_sum_q, o_sum_d;
  logic            o_cout_q, o_cout_d, o_zero_q, o_zero_d;
  logic            busy_q, busy_d;

  logic            gnt0_c, gnt1_c;
  logic [DW-1:0]   add_b_c, add_sum_c;
  logic            add_cout_c;

  // Round robin: on contention the requester that did not win last time goes.
  always_comb begin
    gnt0_c = !rst && (state_q == IDLE) && r0_valid && (!r1_valid || last_q);
    gnt1_c = !rst && (state_q == IDLE) && r1_valid && (!r0_valid || !last_q);
  end

  // Subtract is A + ~B + 1 so the carry-out doubles as a no-borrow flag.
  always_comb begin
    add_b_c = op_q ? ~b_q : b_q;
  end

  add32 u_add32 (
    .a_i    (a_q),
    .b_i    (add_b_c),
    .cin_i  (op_q),
    .sum_o  (add_sum_c),
    .cout_o (add_cout_c)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_id_d    = o_id_q;
    o_sum_d   = o_sum_q;
    o_cout_d  = o_cout_q;
    o_zero_d  = o_zero_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0_c || gnt1_c) begin
          a_d     = gnt1_c ? r1_a  : r0_a;
          b_d     = gnt1_c ? r1_b  : r0_b;
          op_d    = gnt1_c ? r1_op : r0_op;
          id_d    = gnt1_c;
          last_d  = gnt1_c;
          cnt_d   = CW'(LAT - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          o_sum_d   = add_sum_c;
          o_cout_d  = add_cout_c;
          o_zero_d  = (add_sum_c == '0);
          o_id_d    = id_q;
          o_valid_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (o_ready) begin
          o_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_id_q    <= 1'b0;
      o_sum_q   <= '0;
      o_cout_q  <= 1'b0;
      o_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_id_q    <= o_id_d;
      o_sum_q   <= o_sum_d;
      o_cout_q  <= o_cout_d;
      o_zero_q  <= o_zero_d;
      busy_q    <= busy_d;
    end
  end

  assign r0_ready = gnt0_c;
  assign r1_ready = gnt1_c;
  assign o_valid  = o_valid_q;
  assign o_id     = o_id_q;
  assign o_sum    = o_sum_q;
  assign o_cout   = o_cout_q;
  assign o_zero   = o_zero_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: two instances (LAT=1, LAT=3) share stimulus and are
// compared every cycle against a transaction-level model of the arbiter.

module tb_addsub_arbiter;
  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_op, r1_valid, r1_op, o_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;

  logic [1:0]       rdy0, rdy1, ov, oid, ocout, ozero, obusy;
  logic [1:0][31:0] osum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state per instance.
  int          lat_of [2] = '{int'(LAT0), int'(LAT1)};
  bit          m_idle [2];
  bit          m_outv [2];
  bit          m_last [2];
  bit          m_id   [2];
  bit          m_cout [2];
  bit          m_zero [2];
  logic [31:0] m_sum  [2];
  bit          p_id   [2];
  bit          p_cout [2];
  logic [31:0] p_sum  [2];
  int          m_vat  [2];

  always #5 clk = ~clk;

  addsub_arbiter #(.LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rdy0[0]), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(rdy1[0]), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .o_valid(ov[0]), .o_ready(o_ready), .o_id(oid[0]), .o_sum(osum[0]),
    .o_cout(ocout[0]), .o_zero(ozero[0]), .busy(obusy[0])
  );

  addsub_arbiter #(.LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rdy0[1]), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(rdy1[1]), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .o_valid(ov[1]), .o_ready(o_ready), .o_id(oid[1]), .o_sum(osum[1]),
    .o_cout(ocout[1]), .o_zero(ozero[1]), .busy(obusy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // {cout, sum}: subtract carry means "no borrow", i.e. A >= B unsigned.
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub);
    if (!sub) return {1'b0, a} + {1'b0, b};
    return {(a >= b), a - b};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1; m_outv[k] = 1'b0; m_last[k] = 1'b1; m_id[k] = 1'b0;
      m_cout[k] = 1'b0; m_zero[k] = 1'b0; m_sum[k] = '0; m_vat[k] = 0;
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the coming edge.
  task automatic eval();
    for (int k = 0; k < 2; k++) begin
      bit g0, g1;
      logic [32:0] r;
      g0 = !rst && m_idle[k] && r0_valid && (!r1_valid || m_last[k]);
      g1 = !rst && m_idle[k] && r1_valid && (!r0_valid || !m_last[k]);
      check($sformatf("r0_ready[%0d]", k), 32'(rdy0[k]), 32'(g0));
      check($sformatf("r1_ready[%0d]", k), 32'(rdy1[k]), 32'(g1));
      check($sformatf("busy[%0d]", k),     32'(obusy[k]), 32'(!m_idle[k]));
      check($sformatf("o_valid[%0d]", k),  32'(ov[k]), 32'(m_outv[k]));
      check($sformatf("o_sum[%0d]", k),    osum[k], m_sum[k]);
      check($sformatf("o_cout[%0d]", k),   32'(ocout[k]), 32'(m_cout[k]));
      check($sformatf("o_zero[%0d]", k),   32'(ozero[k]), 32'(m_zero[k]));
      check($sformatf("o_id[%0d]", k),     32'(oid[k]), 32'(m_id[k]));
      if (rst) begin
        m_idle[k] = 1'b1; m_outv[k] = 1'b0; m_last[k] = 1'b1; m_id[k] = 1'b0;
        m_cout[k] = 1'b0; m_zero[k] = 1'b0; m_sum[k] = '0;
      end else if (g0 || g1) begin
        r = g1 ? ref_op(r1_a, r1_b, r1_op) : ref_op(r0_a, r0_b, r0_op);
        p_sum[k]  = r[31:0];
        p_cout[k] = r[32];
        p_id[k]   = g1;
        m_last[k] = g1;
        m_idle[k] = 1'b0;
        m_vat[k]  = cyc + lat_of[k] + 1;
      end else if (!m_idle[k] && !m_outv[k] && (cyc + 1 == m_vat[k])) begin
        m_outv[k] = 1'b1;
        m_sum[k]  = p_sum[k];
        m_cout[k] = p_cout[k];
        m_zero[k] = (p_sum[k] == '0);
        m_id[k]   = p_id[k];
      end else if (m_outv[k] && o_ready) begin
        m_outv[k] = 1'b0;
        m_idle[k] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    #3 eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Single-cycle request from one requester while both instances are idle.
  task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b, input bit op);
    if (!who) begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
    else      begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
    cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r0_a = $urandom; r0_b = $urandom; r1_a = $urandom; r1_b = $urandom;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] edges [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; o_ready = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; r0_op = 1'b0; r1_op = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Directed arithmetic cases.
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); idle_n(8);
    issue(1'b1, 32'd5, 32'd7, 1'b1);                 idle_n(8);
    issue(1'b1, 32'd7, 32'd5, 1'b1);                 idle_n(8);
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0); idle_n(8);

    // Contention with the consumer always ready.
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r0_a = rnd_word(); r0_b = rnd_word(); r0_op = 1'($urandom);
      r1_a = rnd_word(); r1_b = rnd_word(); r1_op = 1'($urandom);
      cycle();
    end

    // Backpressure while both requesters keep asking.
    o_ready = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    o_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    idle_n(8);

    // Reset two cycles after a handshake, then check r0 regains priority.
    issue(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1);
    cycle();
    rst = 1'b1; cycle();
    rst = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    idle_n(8);

    // Randomized traffic, stalls and occasional resets.
    for (int i = 0; i < 600; i++) begin
      r0_valid = ($urandom_range(0, 2) != 0);
      r1_valid = ($urandom_range(0, 2) != 0);
      r0_a = rnd_word(); r0_b = rnd_word(); r0_op = 1'($urandom);
      r1_a = rnd_word(); r1_b = rnd_word(); r1_op = 1'($urandom);
      o_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 1'b0;
    o_ready = 1'b1;
    idle_n(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one add32 instance between two requesters for 32-bit add/subtract.
- Each requester issues an operation through a valid/ready handshake; a round-robin arbiter grants one request at a time.
- The block sequences the shared adder through a fixed multi-cycle execute window, then returns a registered result tagged with the requester id over a valid/ready response port.
- Sits between the ALU-side clients and the ripple adder chain.

Parameters:
- LAT, default 1, execute-window cycles allowed for the ripple adder to settle; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- r0_valid  input  1  requester 0 has an operation pending.
- r0_ready  output  1  requester 0 is granted this cycle.
- r0_a  input  32  requester 0 operand A.
- r0_b  input  32  requester 0 operand B.
- r0_op  input  1  requester 0 operation: 0 = add (A+B), 1 = subtract (A-B).
- r1_valid, r1_ready, r1_a, r1_b, r1_op: same widths and meaning as the r0 ports, for requester 1.
- o_valid  output  1  result available.
- o_ready  input  1  consumer accepts the result.
- o_id  output  1  id of the requester that owns the result.
- o_sum  output  32  result.
- o_cout  output  1  adder carry-out.
- o_zero  output  1  high when o_sum == 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high (rst sampled on the rising edge of clk).
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- Reset values: o_valid=0, o_id=0, o_sum=0, o_cout=0, o_zero=0, busy=0, LAT counter=0. Round-robin pointer last_grant=1, so r0 wins the first contested grant. r0_ready and r1_ready are forced 0 while rst=1.
- IDLE, grant rule:
  - Ready outputs are combinational, from the valid inputs and last_grant.
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester != last_grant gets ready=1.
  - At most one ready is high in any cycle. Ready is never high outside IDLE.
- IDLE, handshake (valid & ready at cycle T):
  - Register A, B, op and id.
  - Set last_grant=id and counter=LAT-1.
  - Move to EXEC at T+1.
- Operands are sampled only at the handshake. A requester may drop valid before being granted; it is then simply not granted. Operand changes after the handshake have no effect.
- EXEC:
  - Registered operands drive the internal add32.
  - Subtract: B is inverted bitwise and cin=1. Add: B is passed through and cin=0.
  - Each EXEC cycle with counter != 0 decrements the counter.
  - On the EXEC cycle with counter == 0 (cycle T+LAT): capture o_sum, o_cout, o_zero and o_id; set o_valid=1; move to DONE.
  - First cycle with o_valid=1 is T+LAT+1.
- Arithmetic: o_sum is 32-bit modulo-2^32. o_cout is the raw carry-out: for add, 1 on unsigned overflow; for subtract, 1 means A >= B unsigned (no borrow). No signed overflow flag.
- DONE:
  - o_valid and all result fields are held stable until o_valid & o_ready.
  - On acceptance: o_valid=0 next cycle, return to IDLE. Result fields keep their last values.
  - No grant is issued in the acceptance cycle; the earliest next grant is the following cycle.
  - Minimum issue interval is LAT+2 cycles.
- Backpressure: o_ready low in DONE stalls indefinitely. Both ready outputs stay 0, and pending requests wait without being dropped.
- Reset mid-operation (EXEC or DONE): the transaction is abandoned with no response. The next cycle is IDLE with all reset values, including r0 priority.
- busy=1 from T+1 through the acceptance cycle inclusive.

Test Plan:
- Add with overflow: rst, then r0: a=0xFFFF_FFFF, b=0x0000_0001, op=0, LAT=1 -> handshake at T; o_valid at T+2 with o_sum=0x0000_0000, o_cout=1, o_zero=1, o_id=0.
- Subtract, both borrow cases on r1:
  - a=5, b=7, op=1 -> o_sum=0xFFFF_FFFE, o_cout=0, o_zero=0, o_id=1.
  - then a=7, b=5 -> o_sum=0x0000_0002, o_cout=1.
- Contention: both valid held high from reset release, o_ready tied 1 -> grants alternate r0, r1, r0, r1; o_id sequence 0,1,0,1; never two readies in one cycle; handshakes spaced LAT+2 cycles.
- Backpressure: hold o_ready=0 for 5 cycles in DONE while r0 and r1 are valid -> o_valid, o_sum and o_id stable for all 5 cycles; r0_ready=r1_ready=0; grant occurs in the cycle after the acceptance cycle.
- Reset mid-EXEC with LAT=4: assert rst at T+2 -> o_valid never rises for that op; busy=0 after reset; with both requesters valid, the first post-reset grant goes to r0.
- Latency parameter: LAT=3, a=0x1234_5678, b=0x1111_1111, op=0 -> o_valid first high at T+4 with o_sum=0x2345_6789, o_cout=0.
